// File: rtl/etc_block_scheduler.sv
// ETC2 RGB block scheduler: classifies each incoming 64-bit block into one of five
// colour modes, strobes the decoders until they report ready (or a timeout expires),
// then holds the captured result for the pixel stage until it is accepted.
module etc_block_scheduler #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        sclk,
    input  logic        rsrt,
    input  logic        blk_valid,
    output logic        blk_ready,
    input  logic [63:0] blk_data,
    output logic        dec_rtr,
    output logic [2:0]  dec_mode,
    output logic [63:0] dec_block,
    input  logic        dec_rts,
    input  logic [23:0] dec_c0,
    input  logic [23:0] dec_c1,
    input  logic [23:0] dec_c2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_mode,
    output logic [63:0] out_block,
    output logic [23:0] out_c0,
    output logic [23:0] out_c1,
    output logic [23:0] out_c2,
    output logic [15:0] blk_cnt,
    output logic        err_timeout
);

    localparam logic [2:0] ModeIndividual   = 3'd0;
    localparam logic [2:0] ModeDifferential = 3'd1;
    localparam logic [2:0] ModeT            = 3'd2;
    localparam logic [2:0] ModeH            = 3'd3;
    localparam logic [2:0] ModePlanar       = 3'd4;

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StIssue, StOut} state_e;

    state_e      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] blk_cnt_q;
    logic [2:0]  blk_mode;
    logic [6:0]  sum_r, sum_g, sum_b;
    logic        blk_accept, issue_done, timeout_hit, out_fire;

    // Mode classification: a base+delta channel that leaves 0..31 selects T/H/Planar.
    always_comb begin
        sum_r = {2'b00, blk_data[63:59]} + {{4{blk_data[58]}}, blk_data[58:56]};
        sum_g = {2'b00, blk_data[55:51]} + {{4{blk_data[50]}}, blk_data[50:48]};
        sum_b = {2'b00, blk_data[47:43]} + {{4{blk_data[42]}}, blk_data[42:40]};
        if (!blk_data[33]) begin
            blk_mode = ModeIndividual;
        end else if (sum_r[6:5] != 2'b00) begin
            blk_mode = ModeT;
        end else if (sum_g[6:5] != 2'b00) begin
            blk_mode = ModeH;
        end else if (sum_b[6:5] != 2'b00) begin
            blk_mode = ModePlanar;
        end else begin
            blk_mode = ModeDifferential;
        end
    end

    // Handshake and timeout qualifiers; dec_rts only matters while issuing.
    always_comb begin
        blk_accept  = (state_q == StIdle) && blk_valid;
        issue_done  = (state_q == StIssue) && dec_rts;
        timeout_hit = (state_q == StIssue) && !dec_rts && ((wait_cnt_q + 8'd1) == TimeoutCnt);
        out_fire    = (state_q == StOut) && out_ready;
        wait_cnt_d  = wait_cnt_q;
        if (blk_accept) begin
            wait_cnt_d = 8'd0;
        end else if ((state_q == StIssue) && !dec_rts) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge sclk or negedge rsrt) begin
        if (!rsrt) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (blk_valid) state_d = StIssue;
            StIssue: if (dec_rts || timeout_hit) state_d = StOut;
            StOut:   if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs; rtr follows the state so reset drops it without waiting for a clock.
    always_comb begin
        blk_ready = (state_q == StIdle);
        dec_rtr   = (state_q == StIssue);
        out_valid = (state_q == StOut);
    end

    // Datapath: issue registers, captured result, counters and sticky error.
    always_ff @(posedge sclk or negedge rsrt) begin
        if (!rsrt) begin
            dec_block   <= 64'd0;
            dec_mode    <= ModeIndividual;
            out_block   <= 64'd0;
            out_mode    <= ModeIndividual;
            out_c0      <= 24'd0;
            out_c1      <= 24'd0;
            out_c2      <= 24'd0;
            wait_cnt_q  <= 8'd0;
            blk_cnt_q   <= 16'd0;
            err_timeout <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            if (blk_accept) begin
                dec_block <= blk_data;
                dec_mode  <= blk_mode;
            end
            if (issue_done || timeout_hit) begin
                out_block <= dec_block;
                out_mode  <= dec_mode;
            end
            if (issue_done) begin
                out_c0 <= dec_c0;
                out_c1 <= dec_c1;
                out_c2 <= dec_c2;
            end else if (timeout_hit) begin
                out_c0      <= 24'd0;
                out_c1      <= 24'd0;
                out_c2      <= 24'd0;
                err_timeout <= 1'b1;
            end
            if (out_fire) begin
                blk_cnt_q <= blk_cnt_q + 16'd1;
            end
        end
    end

    assign blk_cnt = blk_cnt_q;

endmodule

// File: tb/tb_etc_block_scheduler.sv
// Directed bench for etc_block_scheduler: classification, decoder handshake,
// timeout abort, output back-pressure, asynchronous reset and counter wrap.
module tb_etc_block_scheduler;

    logic        sclk;
    logic        rsrt;
    logic        blk_valid;
    logic        blk_ready;
    logic [63:0] blk_data;
    logic        dec_rtr;
    logic [2:0]  dec_mode;
    logic [63:0] dec_block;
    logic        dec_rts;
    logic [23:0] dec_c0, dec_c1, dec_c2;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_mode;
    logic [63:0] out_block;
    logic [23:0] out_c0, out_c1, out_c2;
    logic [15:0] blk_cnt;
    logic        err_timeout;

    int n_cmp = 0;
    int n_err = 0;
    int rtr_cnt;

    etc_block_scheduler #(.TIMEOUT(15)) dut (
        .sclk        (sclk),
        .rsrt        (rsrt),
        .blk_valid   (blk_valid),
        .blk_ready   (blk_ready),
        .blk_data    (blk_data),
        .dec_rtr     (dec_rtr),
        .dec_mode    (dec_mode),
        .dec_block   (dec_block),
        .dec_rts     (dec_rts),
        .dec_c0      (dec_c0),
        .dec_c1      (dec_c1),
        .dec_c2      (dec_c2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_mode    (out_mode),
        .out_block   (out_block),
        .out_c0      (out_c0),
        .out_c1      (out_c1),
        .out_c2      (out_c2),
        .blk_cnt     (blk_cnt),
        .err_timeout (err_timeout)
    );

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one block, then answer rtr with rts on rtr cycle (lat+1); lat<0 = never.
    // Returns with the DUT out of ISSUE (or after a bounded wait) and rtr_cnt set.
    task automatic issue_block(input logic [63:0] data, input int lat,
                               input logic [23:0] c0, input logic [23:0] c1,
                               input logic [23:0] c2);
        int guard;
        @(negedge sclk);
        blk_valid = 1'b1;
        blk_data  = data;
        @(negedge sclk);
        blk_valid = 1'b0;
        dec_c0 = c0;
        dec_c1 = c1;
        dec_c2 = c2;
        rtr_cnt = 0;
        guard = 0;
        while (dec_rtr && guard < 100) begin
            rtr_cnt++;
            dec_rts = (lat >= 0) && (rtr_cnt == lat + 1);
            @(negedge sclk);
            guard++;
        end
        dec_rts = 1'b0;
    endtask

    // Accept the pending result; caller is at a negedge with the DUT in OUT.
    task automatic accept_out();
        out_ready = 1'b1;
        @(negedge sclk);
        out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge sclk);
        rsrt = 1'b0;
        @(negedge sclk);
        rsrt = 1'b1;
    endtask

    initial begin
        rsrt      = 1'b0;
        blk_valid = 1'b0;
        blk_data  = 64'd0;
        dec_rts   = 1'b0;
        dec_c0    = 24'd0;
        dec_c1    = 24'd0;
        dec_c2    = 24'd0;
        out_ready = 1'b0;

        // Reset state.
        repeat (3) @(negedge sclk);
        check("rst_dec_rtr", 64'(dec_rtr), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_err", 64'(err_timeout), 64'd0);
        check("rst_blk_cnt", 64'(blk_cnt), 64'd0);
        check("rst_dec_mode", 64'(dec_mode), 64'd0);
        check("rst_out_block", out_block, 64'd0);
        rsrt = 1'b1;
        @(negedge sclk);
        check("rst_blk_ready", 64'(blk_ready), 64'd1);

        // Planar block, rts one cycle after rtr.
        issue_block(64'h0000_F902_0000_0000, 1, 24'h123456, 24'h654321, 24'hABCDEF);
        check("pl_dec_mode", 64'(dec_mode), 64'd4);
        check("pl_dec_block", dec_block, 64'h0000_F902_0000_0000);
        check("pl_rtr_cycles", 64'(rtr_cnt), 64'd2);
        check("pl_out_valid", 64'(out_valid), 64'd1);
        check("pl_out_c0", 64'(out_c0), 64'h123456);
        check("pl_out_c2", 64'(out_c2), 64'hABCDEF);
        check("pl_out_mode", 64'(out_mode), 64'd4);
        check("pl_blk_ready", 64'(blk_ready), 64'd0);
        accept_out();
        check("pl_blk_cnt", 64'(blk_cnt), 64'd1);
        check("pl_idle_ready", 64'(blk_ready), 64'd1);

        // Mode sequence after a fresh reset.
        pulse_reset();
        check("seq_cnt_reset", 64'(blk_cnt), 64'd0);
        issue_block(64'h0000_0000_0000_0000, 1, 24'h000001, 24'd0, 24'd0);
        check("seq_mode_ind", 64'(out_mode), 64'd0);
        check("seq_c0_ind", 64'(out_c0), 64'h000001);
        accept_out();
        issue_block(64'h0000_0002_0000_0000, 1, 24'h000002, 24'd0, 24'd0);
        check("seq_mode_diff", 64'(out_mode), 64'd1);
        accept_out();
        issue_block(64'hF900_0002_0000_0000, 1, 24'h000003, 24'd0, 24'd0);
        check("seq_mode_t", 64'(out_mode), 64'd2);
        check("seq_out_block", out_block, 64'hF900_0002_0000_0000);
        accept_out();
        check("seq_blk_cnt", 64'(blk_cnt), 64'd3);
        issue_block(64'h0007_0002_0000_0000, 0, 24'h000004, 24'd0, 24'd0);
        check("seq_mode_h", 64'(out_mode), 64'd3);
        check("seq_rtr_lat0", 64'(rtr_cnt), 64'd1);
        accept_out();
        issue_block(64'h2D00_0002_0000_0000, 3, 24'h000005, 24'd0, 24'd0);
        check("seq_mode_diff2", 64'(out_mode), 64'd1);
        check("seq_rtr_lat3", 64'(rtr_cnt), 64'd4);
        accept_out();
        check("seq_blk_cnt5", 64'(blk_cnt), 64'd5);

        // dec_rts while idle is ignored.
        dec_rts = 1'b1;
        repeat (2) @(negedge sclk);
        dec_rts = 1'b0;
        check("idle_rts_valid", 64'(out_valid), 64'd0);
        check("idle_rts_ready", 64'(blk_ready), 64'd1);

        // Output back-pressure for 10 cycles.
        issue_block(64'h0000_0002_0000_0000, 1, 24'hC0FFEE, 24'h111111, 24'h222222);
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_c0", 64'(out_c0), 64'hC0FFEE);
            check("bp_blk_ready", 64'(blk_ready), 64'd0);
            check("bp_blk_cnt", 64'(blk_cnt), 64'd5);
            @(negedge sclk);
        end
        accept_out();
        check("bp_cnt_after", 64'(blk_cnt), 64'd6);
        check("bp_idle", 64'(blk_ready), 64'd1);

        // Decoder never answers: timeout abort.
        dec_c0 = 24'hFFFFFF;
        issue_block(64'hF900_0002_0000_0000, -1, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
        check("to_rtr_cycles", 64'(rtr_cnt), 64'd15);
        check("to_err", 64'(err_timeout), 64'd1);
        check("to_out_valid", 64'(out_valid), 64'd1);
        check("to_out_c0", 64'(out_c0), 64'd0);
        check("to_out_c1", 64'(out_c1), 64'd0);
        check("to_out_c2", 64'(out_c2), 64'd0);
        accept_out();
        check("to_blk_cnt", 64'(blk_cnt), 64'd7);
        issue_block(64'h0000_F902_0000_0000, 1, 24'h0A0B0C, 24'd0, 24'd0);
        check("to_next_c0", 64'(out_c0), 64'h0A0B0C);
        check("to_next_mode", 64'(out_mode), 64'd4);
        check("to_err_sticky", 64'(err_timeout), 64'd1);
        accept_out();
        check("to_next_cnt", 64'(blk_cnt), 64'd8);

        // Asynchronous reset in the middle of ISSUE.
        @(negedge sclk);
        blk_valid = 1'b1;
        blk_data  = 64'h0000_0002_0000_0000;
        @(negedge sclk);
        blk_valid = 1'b0;
        check("ar_rtr_before", 64'(dec_rtr), 64'd1);
        #2 rsrt = 1'b0;
        #1;
        check("ar_rtr_async", 64'(dec_rtr), 64'd0);
        check("ar_blk_cnt", 64'(blk_cnt), 64'd0);
        check("ar_err", 64'(err_timeout), 64'd0);
        check("ar_dec_block", dec_block, 64'd0);
        @(negedge sclk);
        rsrt = 1'b1;
        dec_rts = 1'b1;
        @(negedge sclk);
        dec_rts = 1'b0;
        check("ar_no_out", 64'(out_valid), 64'd0);
        check("ar_ready", 64'(blk_ready), 64'd1);

        // Counter wrap.
        @(negedge sclk);
        force dut.blk_cnt_q = 16'hFFFF;
        @(negedge sclk);
        release dut.blk_cnt_q;
        @(negedge sclk);
        check("wr_cnt_forced", 64'(blk_cnt), 64'hFFFF);
        issue_block(64'h0000_0000_0000_0000, 1, 24'h000009, 24'd0, 24'd0);
        accept_out();
        check("wr_cnt_wrap", 64'(blk_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
